// File: rtl/bit_enum_pkg.sv
// Shared definitions for the bit_enumerator slice: default word width and
// the controller state encoding.
package bit_enum_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

endpackage

// File: rtl/lowest_set_bit.sv
// Combinational log-depth priority encoder: index of the lowest set bit of
// vec_i plus a flag saying whether any bit was set (index is 0 when none).
module lowest_set_bit
  import bit_enum_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEFAULT,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  localparam int LEAVES = 1 << IDX_W;

  // Binary tree of (found, index) pairs; each node prefers its lower half.
  for (genvar l = 0; l <= IDX_W; l++) begin : g_lvl
    localparam int N = LEAVES >> l;
    logic [N-1:0]     f;
    logic [IDX_W-1:0] ix [N];

    if (l == 0) begin : g_leaf
      for (genvar j = 0; j < N; j++) begin : g_bit
        if (j < WIDTH) begin : g_real
          assign f[j] = vec_i[j];
        end else begin : g_pad
          assign f[j] = 1'b0;
        end
        assign ix[j] = IDX_W'(j);
      end
    end else begin : g_node
      for (genvar j = 0; j < N; j++) begin : g_pair
        assign f[j]  = g_lvl[l-1].f[2*j] | g_lvl[l-1].f[2*j+1];
        assign ix[j] = g_lvl[l-1].f[2*j] ? g_lvl[l-1].ix[2*j]
                                         : g_lvl[l-1].ix[2*j+1];
      end
    end
  end

  assign found_o = g_lvl[IDX_W].f[0];
  assign idx_o   = found_o ? g_lvl[IDX_W].ix[0] : '0;

endmodule

// File: rtl/bit_enumerator.sv
// Serial decomposer: accepts a word, then emits one beat per set bit
// (lowest first); a zero word yields a single beat flagged out_none.
module bit_enumerator
  import bit_enum_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEFAULT,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [IDX_W-1:0] out_ordinal,
  output logic             out_last,
  output logic             out_none
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] resid_q, resid_d;
  logic [IDX_W-1:0] ord_q, ord_d;
  logic             zero_q, zero_d;

  logic [IDX_W-1:0] enc_idx;
  logic             enc_found;
  logic [WIDTH-1:0] resid_nolsb;
  logic             last_w;
  logic             emitting;

  lowest_set_bit #(
    .WIDTH (WIDTH)
  ) u_lsb (
    .vec_i   (resid_q),
    .idx_o   (enc_idx),
    .found_o (enc_found)
  );

  assign resid_nolsb = resid_q & (resid_q - WIDTH'(1));
  assign last_w      = zero_q | (resid_nolsb == '0);
  assign emitting    = (state_q == EMIT);

  always_comb begin
    state_d = state_q;
    resid_d = resid_q;
    ord_d   = ord_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          resid_d = in_data;
          ord_d   = '0;
          zero_d  = (in_data == '0);
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (last_w) begin
            state_d = IDLE;
          end else begin
            resid_d = resid_nolsb;
            ord_d   = ord_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      resid_q <= '0;
      ord_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      resid_q <= resid_d;
      ord_q   <= ord_d;
      zero_q  <= zero_d;
    end
  end

  // Handshake flags depend on state only; beat fields are forced to 0 when idle.
  always_comb begin
    in_ready    = ~emitting;
    out_valid   = emitting;
    out_index   = (emitting && enc_found) ? enc_idx : '0;
    out_ordinal = emitting ? ord_q : '0;
    out_last    = emitting & last_w;
    out_none    = emitting & zero_q;
  end

endmodule

// File: doc/bit_enumerator.md
# bit_enumerator

Serial decomposer that takes a 32-bit word and emits the bit index of every set bit, lowest first, one index per beat. This is the inverse view of the popcount path: the number of beats emitted for a word equals that word's population count. It sits downstream of puzzle-input decode, where per-bit work items are processed one at a time. Both sides use valid/ready handshakes.

## Interface
- WIDTH, 32, input word width.
- IDX_W, $clog2(WIDTH) = 5, index width. Derived from WIDTH; never overridden.
- clk, input, 1, sole clock. Every flop is rising-edge.
- rst_n, input, 1, reset. Asynchronous assertion, active-low.
- in_valid, input, 1, in_data is valid.
- in_ready, output, 1, block accepts a word this cycle.
- in_data, input, WIDTH, word to enumerate.
- out_valid, output, 1, beat fields below are valid.
- out_ready, input, 1, consumer takes the beat this cycle.
- out_index, output, IDX_W, position of the current set bit.
- out_ordinal, output, IDX_W, 0-based count of the beat within the current word.
- out_last, output, 1, final beat of the current word.
- out_none, output, 1, word was zero. Beat carries no index.

## Operation
- Registers:
  - state: IDLE or EMIT.
  - resid[WIDTH-1:0]: bits not yet emitted.
  - ord[IDX_W-1:0]: beat counter.
  - zero_flag: set when the accepted word was zero.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: resid<=in_data, ord<=0, zero_flag<=(in_data==0), state<=EMIT.
- EMIT:
  - in_ready=0, out_valid=1.
  - out_index = position of the lowest set bit of resid, produced by the priority encoder.
  - out_ordinal = ord.
  - out_none = zero_flag.
  - out_last = zero_flag || ((resid & (resid-1)) == 0).
- Handshake in EMIT (out_valid&&out_ready):
  - If out_last: state<=IDLE.
  - Otherwise: clear the lowest set bit (resid<=resid&(resid-1)) and ord<=ord+1.
- Zero word: exactly one beat with out_none=1, out_last=1, out_index=0, out_ordinal=0.
- Beat count per non-zero word = popcount(in_data), range 1..32.
  - ord never exceeds 31, so it never wraps.
- Backpressure: while out_valid=1 and out_ready=0, every out_* signal holds stable. The producer must not drop valid.
- Output fields are don't-care while out_valid=0, but out_index, out_ordinal, out_last and out_none are driven to 0 in that case.
- Reset (rst_n=0), including mid-word:
  - state=IDLE, resid=0, ord=0, zero_flag=0.
  - Therefore out_valid=0, in_ready=1 and all out_* fields = 0.
  - The partially emitted word is discarded; no completion beat is sent.

## Timing
- Word accepted at edge N → first beat valid in cycle N+1. Fields come directly from registers plus the encoder; there is no extra pipeline stage.
- Sustained rate: one beat per cycle while out_ready=1.
- Cost per word: popcount(w) beats + 1 IDLE accept cycle (1 beat for a zero word).
- Last-beat handshake at edge M → in_ready=1 in cycle M+1.
  - There is no same-cycle overlap: in_ready is never high while out_valid is high.
- in_ready and out_valid are decoded from state only. There is no combinational path from out_ready to in_ready, or from in_valid to out_valid.

## Structure
- Package bit_enum_pkg holds:
  - WIDTH_DEFAULT=32.
  - The state enum (IDLE, EMIT).
- Sub-module lowest_set_bit, purely combinational:
  - Input: WIDTH-bit vector.
  - Outputs: IDX_W-bit index and a found flag.
  - Implemented as a log-depth priority encoder. bit_enumerator instantiates it once on resid.
- Top-level logic is the FSM, resid/ord/zero_flag registers and output muxing.

## Test plan
- in_data=0x00000000 → one beat (none=1, last=1, index=0, ordinal=0); in_ready is back to 1 on the following cycle.
- in_data=0x80000001, out_ready=1 → beats (index 0, ordinal 0, last 0) then (index 31, ordinal 1, last 1); none=0 throughout.
- in_data=0xFFFFFFFF, out_ready=1 → 32 consecutive beats with index = ordinal = 0..31, last only on index 31; in_ready is low for exactly 32 cycles.
- in_data=0x00000110, out_ready low for 3 cycles after out_valid rises → index 4 held stable for all 3 cycles, then beats 4 and 8; last=1 only on 8.
- in_data=0x000000F0, rst_n pulsed low after 2 beats → out_valid=0 immediately (asynchronously); after release in_ready=1; next word 0x00000002 yields a single beat (index 1, ordinal 0, last 1).
- in_valid held high with 0x00000001 then 0x00000004 → index 0 (last), one idle accept cycle, then index 2 (last). Total beats equal the summed popcount of 2.
